// File: rtl/fifo_pkt_reader.sv
// fifo_pkt_reader
//   Drains length-prefixed packets from a first-word-fall-through FIFO. The
//   header word is consumed and dropped. Its low LEN_WIDTH bits give the
//   payload length in words. The payload is then presented as a ready/valid
//   stream with an end-of-packet marker.
//
//   Optional feature macro: FIFO_PKT_RD_TIMEOUT_EN
//     If this macro is defined, a packet that starves mid-payload for
//     TIMEOUT_CYC empty cycles is aborted. The reader then emits a zero word
//     with m_last set and pulses pkt_err.
//
// Ports
//   clk         single clock, shared with the FIFO
//   rst_n       asynchronous active-low reset
//   fifo_dout   FWFT head word, valid while !fifo_empty
//   fifo_empty  FIFO empty flag
//   fifo_rd_en  pop request (combinational)
//   m_data      payload word
//   m_valid     m_data valid
//   m_last      final word of the packet
//   m_ready     consumer accepts the word
//   pkt_err     one-cycle pulse: zero-length header or timeout abort
//   pkt_cnt     packets completed downstream (wraps)
//   busy        packet in progress or output register occupied
//
// States
//   state   | meaning
//   IDLE    | waiting for a header word; pops and parses it
//   PAYLOAD | forwarding payload words, `remaining` still to pop
//   ABORT   | (timeout build only) waiting to emit the zero/last filler word

module fifo_pkt_reader #(
  parameter int DATA_WIDTH  = 32,
  parameter int LEN_WIDTH   = 11,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  pkt_err,
  output logic [15:0]           pkt_cnt,
  output logic                  busy
);

`ifdef FIFO_PKT_RD_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, PAYLOAD, ABORT} state_t;
`else
  typedef enum logic {IDLE, PAYLOAD} state_t;
`endif

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] remaining;
  logic [LEN_WIDTH-1:0] hdr_len;
  logic                 out_free;
  logic                 rd_req;
  logic                 pop_hdr;
  logic                 pop_pay;
  logic                 emit_abort;
  logic                 err_set;
  logic                 tmo_hit;

  assign hdr_len  = fifo_dout[LEN_WIDTH-1:0];
  assign out_free = !m_valid || m_ready;

`ifdef FIFO_PKT_RD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (state == PAYLOAD) && fifo_empty &&
                   (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  // Counts consecutive starved PAYLOAD cycles; a stall caused only by
  // downstream backpressure (FIFO non-empty) neither counts nor clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state != PAYLOAD || pop_pay || tmo_hit) begin
      tmo_cnt <= '0;
    end else if (fifo_empty) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    rd_req     = 1'b0;
    pop_hdr    = 1'b0;
    pop_pay    = 1'b0;
    emit_abort = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        // The header is never forwarded, so it may pop even while the last
        // word of the previous packet still waits in the output register.
        if (!fifo_empty) begin
          rd_req  = 1'b1;
          pop_hdr = 1'b1;
          if (hdr_len == '0) err_set = 1'b1;
          else               state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (!fifo_empty && out_free) begin
          rd_req  = 1'b1;
          pop_pay = 1'b1;
          if (remaining == LEN_WIDTH'(1)) state_nxt = IDLE;
        end
`ifdef FIFO_PKT_RD_TIMEOUT_EN
        else if (tmo_hit) begin
          state_nxt = ABORT;
        end
      end
      ABORT: begin
        if (out_free) begin
          emit_abort = 1'b1;
          err_set    = 1'b1;
          state_nxt  = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gated by reset so the FIFO cannot lose a header while we are held in reset.
  assign fifo_rd_en = rd_req && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      pkt_err   <= 1'b0;
      pkt_cnt   <= '0;
    end else begin
      state   <= state_nxt;
      pkt_err <= err_set;

      if (pop_hdr)      remaining <= hdr_len;
      else if (pop_pay) remaining <= remaining - LEN_WIDTH'(1);

      if (pop_pay) begin
        m_data  <= fifo_dout;
        m_valid <= 1'b1;
        m_last  <= (remaining == LEN_WIDTH'(1));
      end else if (emit_abort) begin
        m_data  <= '0;
        m_valid <= 1'b1;
        m_last  <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end

      if (m_valid && m_ready && m_last) pkt_cnt <= pkt_cnt + 16'd1;
    end
  end

  assign busy = (state != IDLE) || m_valid;

endmodule

// File: tb/tb_fifo_pkt_reader.sv
module tb_fifo_pkt_reader;
  localparam int DW = 32;
  localparam int LW = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready;
  logic          pkt_err;
  logic [15:0]   pkt_cnt;
  logic          busy;

  always #5 clk = ~clk;

  fifo_pkt_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready), .pkt_err(pkt_err), .pkt_cnt(pkt_cnt), .busy(busy)
  );

  int checks = 0, passes = 0, fails = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_data[$];
  bit            exp_last[$];
  int            hs_cyc[$];
  int ref_left = 0, ref_pkts = 0, exp_err = 0, err_seen = 0;
  int pop_left = 0, cyc = 0, gap_run = 0;
  bit stalled_prev = 0;
  logic [DW-1:0] held_data;
  logic          held_last;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: parse the written word stream as packets.
  function automatic void push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    if (ref_left == 0) begin
      ref_left = int'(w[LW-1:0]);
      if (ref_left == 0) exp_err++;
    end else begin
      exp_data.push_back(w);
      exp_last.push_back(ref_left == 1);
      if (ref_left == 1) ref_pkts++;
      ref_left--;
    end
  endfunction

  task automatic tick(input bit rdy, input bit gap);
    logic [DW-1:0] w;
    m_ready    = rdy;
    fifo_empty = gap || (fifo_q.size() == 0);
    fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : DW'($urandom);
    #1;
    if (fifo_rd_en) check("pop_while_empty", DW'(fifo_empty), 0);
    if (stalled_prev) begin
      check("stall_valid", DW'(m_valid), 1);
      check("stall_data", m_data, held_data);
      check("stall_last", DW'(m_last), DW'(held_last));
    end
    if (fifo_rd_en && !fifo_empty) begin
      w = fifo_q.pop_front();
      if (pop_left == 0) pop_left = int'(w[LW-1:0]);
      else begin
        check("payload_pop_while_stalled", DW'(m_valid && !m_ready), 0);
        pop_left--;
      end
    end
    if (m_valid && m_ready) begin
      hs_cyc.push_back(cyc);
      if (exp_data.size() == 0) check("unexpected_word", m_data, 32'hDEAD_BEEF);
      else begin
        check("data", m_data, exp_data.pop_front());
        check("last", DW'(m_last), DW'(exp_last.pop_front()));
      end
    end
    if (pkt_err) err_seen++;
    stalled_prev = m_valid && !m_ready;
    held_data    = m_data;
    held_last    = m_last;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // mode 0: ready always, 1: ready pattern 1,0,0,..., 2: random ready + FIFO gaps
  task automatic drain(input int mode);
    int n = 0;
    bit r, g;
    while ((exp_data.size() != 0 || m_valid || fifo_q.size() != 0) && n < 600) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (n % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      g = (mode == 2) && (gap_run < 3) && ($urandom_range(0, 3) == 0);
      gap_run = g ? gap_run + 1 : 0;
      tick(r, g);
      n++;
    end
    check("drain_timeout", DW'(n >= 600), 0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
  endtask

  task automatic check_totals(input string tag);
    check({tag, "_pkt_cnt"}, DW'(pkt_cnt), DW'(ref_pkts & 16'hFFFF));
    check({tag, "_err_pulses"}, DW'(err_seen), DW'(exp_err));
    check({tag, "_all_delivered"}, DW'(exp_data.size()), 0);
  endtask

  initial begin
    int start;
    logic [DW-1:0] hdr;
    int len;

    rst_n = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1; fifo_dout = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", DW'(m_valid), 0);
    check("rst_last", DW'(m_last), 0);
    check("rst_data", m_data, 0);
    check("rst_err", DW'(pkt_err), 0);
    check("rst_cnt", DW'(pkt_cnt), 0);
    check("rst_busy", DW'(busy), 0);
    check("rst_rd_en", DW'(fifo_rd_en), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single packet: header 3, A B C
    hs_cyc.delete();
    start = cyc;
    push_word(32'd3); push_word(32'hAAAA_0001); push_word(32'hBBBB_0002); push_word(32'hCCCC_0003);
    drain(0);
    check("p1_words", DW'(hs_cyc.size()), 3);
    if (hs_cyc.size() == 3) begin
      check("p1_first_latency", DW'(hs_cyc[0] - start), 2);
      check("p1_consecutive", DW'(hs_cyc[2] - hs_cyc[0]), 2);
    end
    check("p1_busy_low", DW'(busy), 0);
    check_totals("p1");

    // back-to-back len 2 then len 1: one bubble for the second header
    hs_cyc.delete();
    push_word(32'd2); push_word(32'h1111_1111); push_word(32'h2222_2222);
    push_word(32'd1); push_word(32'h3333_3333);
    drain(0);
    check("p2_words", DW'(hs_cyc.size()), 3);
    if (hs_cyc.size() == 3) begin
      check("p2_gap_in_pkt", DW'(hs_cyc[1] - hs_cyc[0]), 1);
      check("p2_gap_between", DW'(hs_cyc[2] - hs_cyc[1]), 2);
    end
    check_totals("p2");

    // backpressure pattern on a len 4 packet
    push_word(32'd4);
    for (int i = 0; i < 4; i++) push_word(32'h4400_0000 + i);
    drain(1);
    check_totals("p3");

    // zero-length header then header 1 + D
    push_word(32'd0); push_word(32'd1); push_word(32'hDDDD_DDDD);
    drain(0);
    check_totals("p4");

    // starved packet: header 4 with only 2 words
    push_word(32'd4); push_word(32'h5500_0001); push_word(32'h5500_0002);
`ifdef FIFO_PKT_RD_TIMEOUT_EN
    exp_data.push_back('0); exp_last.push_back(1'b1);
    exp_err++; ref_pkts++; ref_left = 0;
    repeat (30) tick(1'b1, 1'b0);
    pop_left = 0;
    check("tmo_busy_low", DW'(busy), 0);
    check_totals("tmo");
`else
    repeat (30) tick(1'b1, 1'b0);
    check("stall_busy_high", DW'(busy), 1);
    check_totals("stall");
`endif

    // reset while the output register holds a word
    push_word(32'd5);
    for (int i = 0; i < 4; i++) push_word(32'h6600_0000 + i);
    repeat (4) tick(1'b0, 1'b0);
    check("pre_reset_valid", DW'(m_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", DW'(m_valid), 0);
    check("arst_last", DW'(m_last), 0);
    check("arst_data", m_data, 0);
    check("arst_cnt", DW'(pkt_cnt), 0);
    check("arst_busy", DW'(busy), 0);
    check("arst_rd_en", DW'(fifo_rd_en), 0);
    fifo_q.delete(); exp_data.delete(); exp_last.delete();
    ref_left = 0; pop_left = 0; ref_pkts = 0; exp_err = 0; err_seen = 0;
    stalled_prev = 0;
    fifo_empty = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // upper header bits must be ignored
    push_word(32'hFFFF_F801); push_word(32'h7777_7777);
    drain(0);
    check_totals("post_reset");

    // randomized packets with random backpressure and FIFO gaps
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(0, 6);
      hdr = $urandom;
      hdr[LW-1:0] = LW'(len);
      push_word(hdr);
      for (int i = 0; i < len; i++) push_word($urandom);
    end
    drain(2);
    check_totals("random");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
